channel_stream_mux: RTL and testbench

Multi-channel sample serializer that produces the channel-tagged valid/ready sample stream consumed by the multi-channel FIR filter. Accepts independent per-channel sample strobes from acquisition logic, which has no backpressure, and holds one sample per channel. It emits the samples one word at a time with a channel index, in round-robin order, and flags per-channel overruns when a held sample is replaced before it is sent.

---
 rtl/channel_stream_mux_pkg.sv | 14 +
 rtl/channel_stream_mux_if.sv | 13 +
 rtl/channel_stream_mux_rr_arbiter.sv | 30 +++
 rtl/channel_stream_mux.sv | 89 ++++++++
 tb/tb_channel_stream_mux.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/channel_stream_mux_pkg.sv
// Shared definitions for the channel stream serializer: default sizing,
// channel index type and round-robin index stepping.
package channel_stream_pkg;

  localparam int DEF_CHANNELS   = 4;
  localparam int DEF_DATA_WIDTH = 16;

  typedef logic [$clog2(DEF_CHANNELS)-1:0] chan_idx_t;

  function automatic int next_chan(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/channel_stream_mux_if.sv
// Channel-tagged valid/ready sample stream between the serializer and the FIR.
interface channel_stream_mux_if #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 16
);
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_WIDTH-1:0]       out_data;
  logic [$clog2(CHANNELS)-1:0] out_channel;

  modport master (output out_valid, out_data, out_channel, input out_ready);
  modport slave  (input out_valid, out_data, out_channel, output out_ready);
endinterface

// File: rtl/channel_stream_mux_rr_arbiter.sv
// Combinational round-robin selector: first requester strictly after ptr_i,
// wrapping, so the last served channel has lowest priority.
module channel_rr_arbiter import channel_stream_pkg::*; #(
  parameter int CHANNELS = DEF_CHANNELS
) (
  input  logic [CHANNELS-1:0]         req_i,
  input  logic [$clog2(CHANNELS)-1:0] ptr_i,
  output logic                        gnt_o,
  output logic [$clog2(CHANNELS)-1:0] idx_o
);
  localparam int CW = $clog2(CHANNELS);

  int   c;
  logic found;

  always_comb begin
    found = 1'b0;
    idx_o = '0;
    c     = int'(ptr_i);
    for (int k = 0; k < CHANNELS; k++) begin
      c = next_chan(c, CHANNELS);
      if (!found && req_i[CW'(c)]) begin
        found = 1'b1;
        idx_o = CW'(c);
      end
    end
    gnt_o = found;
  end

endmodule

// File: rtl/channel_stream_mux.sv
// Per-channel sample holding registers serialized round-robin into a single
// registered output slot, with sticky per-channel overrun flags.
module channel_stream_mux import channel_stream_pkg::*; #(
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            sample_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] sample_data,
  channel_stream_mux_if.master           out,
  output logic [CHANNELS-1:0]            pending,
  output logic [CHANNELS-1:0]            overrun,
  input  logic                           overrun_clear
);
  localparam int         CW      = $clog2(CHANNELS);
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [DATA_WIDTH-1:0] hold_q [CHANNELS];
  logic [CHANNELS-1:0]   pend_q, pend_d, ovr_q, ovr_d, load_sel;
  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]         chan_q, chan_d, ptr_q, ptr_d, gnt_idx;
  logic                  gnt, load;

  channel_rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .req_i (pend_q),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign load = gnt && (state_q == S_EMPTY || out.out_ready);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    if (load) begin
      state_d = S_FULL;
      data_d  = hold_q[gnt_idx];
      chan_d  = gnt_idx;
      ptr_d   = gnt_idx;
    end else if (state_q == S_FULL && out.out_ready) begin
      state_d = S_EMPTY;
    end
  end

  // A capture into a channel being loaded this cycle refills it rather than
  // overwriting an unsent sample, so it never counts as an overrun.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign load_sel[i] = load && (gnt_idx == CW'(i));
    assign pend_d[i]   = sample_valid[i] | (pend_q[i] & ~load_sel[i]);
    assign ovr_d[i]    = (sample_valid[i] & pend_q[i] & ~load_sel[i])
                       | (ovr_q[i] & ~overrun_clear);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)               hold_q[i] <= '0;
      else if (sample_valid[i]) hold_q[i] <= sample_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_EMPTY;
      data_q  <= '0;
      chan_q  <= '0;
      ptr_q   <= CW'(CHANNELS - 1);
      pend_q  <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out.out_valid   = (state_q == S_FULL);
  assign out.out_data    = data_q;
  assign out.out_channel = chan_q;
  assign pending         = pend_q;
  assign overrun         = ovr_q;

endmodule

// File: tb/tb_channel_stream_mux.sv
// Bench for channel_stream_mux: constant vector table, directed corner cases,
// and random traffic against a per-cycle behavioural model.
module tb_channel_stream_mux;
  localparam int CH = 4;
  localparam int DW = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [CH-1:0]  sample_valid = '0;
  logic [CH*DW-1:0] sample_data = '0;
  logic           overrun_clear = 1'b0;
  logic [CH-1:0]  pending, overrun;

  always #5 clk = ~clk;

  channel_stream_mux_if #(.CHANNELS(CH), .DATA_WIDTH(DW)) sif ();

  channel_stream_mux #(.CHANNELS(CH), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_valid  (sample_valid),
    .sample_data   (sample_data),
    .out           (sif),
    .pending       (pending),
    .overrun       (overrun),
    .overrun_clear (overrun_clear)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [DW-1:0] m_held [CH];
  logic [CH-1:0] m_pend, m_ovr;
  logic          m_v;
  logic [DW-1:0] m_d;
  int            m_c, m_ptr;

  typedef struct {
    logic [3:0]  sv;
    logic [63:0] sd;
    logic        rdy;
    logic        v;
    logic [1:0]  c;
    logic [15:0] d;
    logic [3:0]  p;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [26:0] dut_o();
    return {sif.out_valid, sif.out_channel, sif.out_data, pending, overrun};
  endfunction

  function automatic logic [26:0] model_o();
    return {m_v, 2'(m_c), m_d, m_pend, m_ovr};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) m_held[i] = '0;
    m_pend = '0; m_ovr = '0; m_v = 1'b0; m_d = '0; m_c = 0; m_ptr = CH - 1;
  endtask

  task automatic model_step(input logic [3:0] sv, input logic [63:0] sd,
                            input logic rdy, input logic clr);
    int g;
    g = -1;
    for (int k = 1; k <= CH; k++) begin
      int c;
      c = (m_ptr + k) % CH;
      if (g < 0 && m_pend[c]) g = c;
    end
    if (g >= 0 && (!m_v || rdy)) begin
      m_v = 1'b1; m_d = m_held[g]; m_c = g; m_ptr = g; m_pend[g] = 1'b0;
    end else if (m_v && rdy) begin
      m_v = 1'b0;
    end
    if (clr) m_ovr = '0;
    for (int i = 0; i < CH; i++)
      if (sv[i]) begin
        if (m_pend[i]) m_ovr[i] = 1'b1;
        m_held[i] = sd[i*DW +: DW];
        m_pend[i] = 1'b1;
      end
  endtask

  task automatic cyc(input logic [3:0] sv, input logic [63:0] sd,
                     input logic rdy, input logic clr);
    sample_valid = sv; sample_data = sd; sif.out_ready = rdy; overrun_clear = clr;
    @(posedge clk);
    model_step(sv, sd, rdy, clr);
    #1;
    chk("model", 64'(dut_o()), 64'(model_o()));
  endtask

  task automatic rst();
    sample_valid = '0; overrun_clear = 1'b0; sif.out_ready = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [63:0] f7, f8, d2;
    f7 = 64'h7FFF_7FFF_7FFF_7FFF;
    f8 = 64'h8000_8000_8000_8000;
    d2 = 64'h0000_1234_0000_0000;
    tbl[0]  = '{4'hF, f7,    1'b1, 1'b0, 2'd0, 16'h0000, 4'hF};
    tbl[1]  = '{4'h0, 64'd0, 1'b1, 1'b1, 2'd0, 16'h7FFF, 4'hE};
    tbl[2]  = '{4'h0, 64'd0, 1'b1, 1'b1, 2'd1, 16'h7FFF, 4'hC};
    tbl[3]  = '{4'h0, 64'd0, 1'b1, 1'b1, 2'd2, 16'h7FFF, 4'h8};
    tbl[4]  = '{4'h0, 64'd0, 1'b1, 1'b1, 2'd3, 16'h7FFF, 4'h0};
    tbl[5]  = '{4'hF, f8,    1'b1, 1'b0, 2'd3, 16'h7FFF, 4'hF};
    tbl[6]  = '{4'h0, 64'd0, 1'b1, 1'b1, 2'd0, 16'h8000, 4'hE};
    tbl[7]  = '{4'h0, 64'd0, 1'b1, 1'b1, 2'd1, 16'h8000, 4'hC};
    tbl[8]  = '{4'h0, 64'd0, 1'b1, 1'b1, 2'd2, 16'h8000, 4'h8};
    tbl[9]  = '{4'h0, 64'd0, 1'b1, 1'b1, 2'd3, 16'h8000, 4'h0};
    tbl[10] = '{4'h0, 64'd0, 1'b1, 1'b0, 2'd3, 16'h8000, 4'h0};
    tbl[11] = '{4'h4, d2,    1'b1, 1'b0, 2'd3, 16'h8000, 4'h4};
    tbl[12] = '{4'h0, 64'd0, 1'b1, 1'b1, 2'd2, 16'h1234, 4'h0};
    tbl[13] = '{4'h0, 64'd0, 1'b1, 1'b0, 2'd2, 16'h1234, 4'h0};

    sif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 64'(dut_o()), 64'd0);
    reset = 1'b1;
    model_reset();

    // Table: full-scale positive/negative bursts, then a single ch2 sample
    foreach (tbl[i]) begin
      cyc(tbl[i].sv, tbl[i].sd, tbl[i].rdy, 1'b0);
      chk($sformatf("tbl%0d", i), {37'd0, sif.out_valid, sif.out_channel, sif.out_data, pending, overrun},
          {37'd0, tbl[i].v, tbl[i].c, tbl[i].d, tbl[i].p, 4'h0});
    end

    // Backpressure holds the beat stable, then back-to-back on release
    rst();
    cyc(4'b0011, 64'h0000_0000_000B_000A, 1'b0, 1'b0);
    cyc(4'b0000, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0000, 64'd0, 1'b0, 1'b0);
      chk("bp_hold", {sif.out_valid, sif.out_channel, sif.out_data}, {1'b1, 2'd0, 16'h000A});
    end
    cyc(4'b0000, 64'd0, 1'b1, 1'b0);
    chk("bp_next", {sif.out_valid, sif.out_channel, sif.out_data}, {1'b1, 2'd1, 16'h000B});
    cyc(4'b0000, 64'd0, 1'b1, 1'b0);
    chk("bp_drain", 64'(sif.out_valid), 64'd0);

    // Overrun: newest wins, emitted once, clear pulse
    rst();
    cyc(4'b0001, 64'd5, 1'b0, 1'b0);
    cyc(4'b0010, 64'd100 << 16, 1'b0, 1'b0);
    cyc(4'b0010, 64'd200 << 16, 1'b0, 1'b0);
    chk("ovr_set", 64'(overrun), 64'h2);
    cyc(4'b0000, 64'd0, 1'b1, 1'b0);
    chk("ovr_data", {sif.out_valid, sif.out_channel, sif.out_data}, {1'b1, 2'd1, 16'd200});
    cyc(4'b0000, 64'd0, 1'b1, 1'b0);
    chk("ovr_once", {sif.out_valid, pending}, 5'd0);
    cyc(4'b0000, 64'd0, 1'b0, 1'b1);
    chk("ovr_clr", 64'(overrun), 64'd0);

    // Capture into a channel in the same cycle it loads the slot
    rst();
    cyc(4'b0001, 64'h11, 1'b1, 1'b0);
    cyc(4'b0001, 64'h22, 1'b1, 1'b0);
    chk("sim_load", 64'(dut_o()), 64'({1'b1, 2'd0, 16'h0011, 4'h1, 4'h0}));
    cyc(4'b0000, 64'd0, 1'b1, 1'b0);
    chk("sim_second", 64'(dut_o()), 64'({1'b1, 2'd0, 16'h0022, 4'h0, 4'h0}));
    cyc(4'b0000, 64'd0, 1'b1, 1'b0);
    chk("sim_drain", 64'(sif.out_valid), 64'd0);

    // Asynchronous reset mid-stream, no stale word afterwards
    rst();
    cyc(4'b0111, 64'h0000_0003_0002_0001, 1'b0, 1'b0);
    cyc(4'b0000, 64'd0, 1'b0, 1'b0);
    chk("rst_pre", {sif.out_valid, pending}, {1'b1, 4'h6});
    #2 reset = 1'b0;
    #1;
    chk("rst_async", 64'(dut_o()), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0000, 64'd0, 1'b1, 1'b0);
      chk("rst_stale", 64'(sif.out_valid), 64'd0);
    end

    // Random traffic against the model
    rst();
    for (int i = 0; i < 600; i++) begin
      logic [3:0] sv;
      sv = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      cyc(sv, {$urandom, $urandom}, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
